// File: rtl/conv3x3_filter.sv
// conv3x3_filter: 3x3 neighbourhood filter on a raster greyscale stream with zero-pad borders and self-timed flush
module conv3x3_filter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] grey_data,
  input  logic             in_ready,
  output logic [PIX_W-1:0] edge_data,
  output logic             out_ready,
  output logic             busy,
  output logic             frame_done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW = PIX_W + 6;
  localparam int KW = $clog2(NPIX + IMG_W + 1);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [KW-1:0] K_RUN = KW'(IMG_W);
  localparam logic [KW-1:0] K_LAST = KW'(NPIX - 1);
  localparam logic [KW-1:0] K_END = KW'(NPIX + IMG_W);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << PIX_W) - 1);
  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [CW-1:0] ci, jc;
  logic [RW-1:0] jr;
  logic [1:0] mode_q;
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  logic [PIX_W-1:0] wl [3];
  logic [PIX_W-1:0] wc [3];
  logic [PIX_W-1:0] wn [3];
  logic [PIX_W-1:0] px [3][3];
  logic proc;
  logic signed [AW-1:0] cs, xs, ds, e, ae, g, s, res;
  assign proc = (state == FLUSH) || in_ready;
  // Assemble the 3x3 neighbourhood of the output pixel; in FLUSH a zero pixel stands in for the missing input
  always_comb begin
    wn[0] = lb2[ci];
    wn[1] = lb1[ci];
    wn[2] = (state == FLUSH) ? '0 : grey_data;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        px[r][c] = ((r == 0 && jr == '0) || (r == 2 && jr == R_LAST) ||
                    (c == 0 && jc == '0) || (c == 2 && jc == C_LAST)) ? '0 :
                   (c == 0) ? wl[r] : (c == 1) ? wc[r] : wn[r];
  end
  // Kernel arithmetic in signed AW-bit precision, selected by the mode latched at frame start
  always_comb begin
    cs = AW'(px[1][1]);
    xs = AW'(px[0][1]) + AW'(px[2][1]) + AW'(px[1][0]) + AW'(px[1][2]);
    ds = AW'(px[0][0]) + AW'(px[0][2]) + AW'(px[2][0]) + AW'(px[2][2]);
    e = (cs <<< 3) - xs - ds;
    ae = e[AW-1] ? -e : e;
    g = ((cs <<< 2) + (xs <<< 1) + ds) >>> 4;
    s = (cs <<< 2) + cs - xs;
    res = (mode_q == 2'd0) ? cs :
          (mode_q == 2'd1) ? ((ae > MAXV) ? MAXV : ae) :
          (mode_q == 2'd2) ? g :
          (s[AW-1] ? '0 : ((s > MAXV) ? MAXV : s));
  end
  // Line buffers and window shift once per processed pixel; contents need no reset since padding masks them
  always_ff @(posedge clk) begin
    if (proc) begin
      lb1[ci] <= wn[2];
      lb2[ci] <= wn[1];
      wl <= wc;
      wc <= wn;
    end
  end
  // Frame sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL;
      k <= '0;
      ci <= '0;
      jc <= '0;
      jr <= '0;
      mode_q <= 2'd0;
      edge_data <= '0;
      out_ready <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_ready <= 1'b0;
      frame_done <= 1'b0;
      if (proc) begin
        k <= k + 1'b1;
        ci <= (ci == C_LAST) ? '0 : ci + 1'b1;
        if (state == FILL && k == '0) mode_q <= mode;
        if (state != FILL) begin
          edge_data <= res[PIX_W-1:0];
          out_ready <= 1'b1;
          jc <= (jc == C_LAST) ? '0 : jc + 1'b1;
          jr <= (jc == C_LAST) ? jr + 1'b1 : jr;
        end
        if (state == FILL && k == K_RUN) state <= RUN;
        if (state == RUN && k == K_LAST) begin
          state <= FLUSH;
          busy <= 1'b1;
        end
        if (state == FLUSH && k == K_END) begin
          state <= FILL;
          busy <= 1'b0;
          frame_done <= 1'b1;
          k <= '0;
          ci <= '0;
          jc <= '0;
          jr <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_filter.sv
// tb_conv3x3_filter: directed tables plus randomized frames checked against a neighbourhood-arithmetic model
module tb_conv3x3_filter;
  localparam int W = 4;
  localparam int H = 3;
  localparam int P = 4;
  localparam int N = W * H;
  localparam int MAXP = (1 << P) - 1;
  typedef struct {
    int sel;
    int r;
    int c;
    int exp;
  } vec_t;
  logic clk = 0;
  logic rst = 0;
  logic [1:0] mode = 0;
  logic [P-1:0] grey_data = 0;
  logic in_ready = 0;
  logic [P-1:0] edge_data;
  logic out_ready, busy, frame_done;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int oq[$];
  int fq[$];
  int cq[$];
  int busy_cnt = 0;
  int gt[4][N];
  conv3x3_filter #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk(clk), .rst(rst), .mode(mode), .grey_data(grey_data), .in_ready(in_ready),
    .edge_data(edge_data), .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (out_ready) begin
      oq.push_back(int'(edge_data));
      fq.push_back(int'(frame_done));
      cq.push_back(cyc);
    end
    if (busy) busy_cnt++;
  end
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask
  function automatic int pix(input int img[N], input int r, input int c);
    return (r < 0 || r >= H || c < 0 || c >= W) ? 0 : img[r*W+c];
  endfunction
  function automatic int ref_out(input int img[N], input int m, input int r, input int c);
    int cc, x, d, e;
    cc = pix(img, r, c);
    x = pix(img, r-1, c) + pix(img, r+1, c) + pix(img, r, c-1) + pix(img, r, c+1);
    d = pix(img, r-1, c-1) + pix(img, r-1, c+1) + pix(img, r+1, c-1) + pix(img, r+1, c+1);
    case (m)
      0: return cc;
      1: begin
        e = 8*cc - x - d;
        if (e < 0) e = -e;
        return (e > MAXP) ? MAXP : e;
      end
      2: return (4*cc + 2*x + d) / 16;
      default: begin
        e = 5*cc - x;
        return (e < 0) ? 0 : ((e > MAXP) ? MAXP : e);
      end
    endcase
  endfunction
  task automatic run_frame(input int img[N], input int m, input int duty, input bit tog,
                           input bit hold, output int got[N]);
    int in_cyc[N];
    int i, ec;
    bit done;
    oq.delete();
    fq.delete();
    cq.delete();
    busy_cnt = 0;
    mode = 2'(m);
    i = 0;
    while (i < N) begin
      @(negedge clk);
      if (tog && i > 0) mode = 2'($urandom);
      in_ready = ($urandom_range(0, 99) < duty);
      grey_data = in_ready ? P'(img[i]) : P'($urandom);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_cyc[i] = cyc;
        i++;
      end
    end
    in_ready = hold;
    grey_data = P'($urandom);
    done = 0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(posedge clk);
      #1;
      if (frame_done) done = 1;
    end
    in_ready = 0;
    if (!done) chk("frame_done timeout", 0, 1);
    @(negedge clk);
    #1;
    chk("output count", oq.size(), N);
    chk("busy cycles", busy_cnt, W + 1);
    for (int j = 0; j < N; j++) begin
      got[j] = (j < oq.size()) ? oq[j] : -1;
      ec = (j <= N - W - 2) ? in_cyc[j+W+1] : in_cyc[N-1] + j - (N - W - 2);
      chk($sformatf("pixel %0d mode %0d", j, m), got[j], ref_out(img, m, j / W, j % W));
      chk($sformatf("frame_done %0d", j), (j < fq.size()) ? fq[j] : -1, (j == N - 1) ? 1 : 0);
      chk($sformatf("timing %0d", j), (j < cq.size()) ? cq[j] : -1, ec);
    end
  endtask
  initial begin
    vec_t tv[$];
    int img[N];
    int g[N];
    int m;
    tv.push_back('{0, 0, 0, 0});
    tv.push_back('{0, 1, 1, 5});
    tv.push_back('{0, 2, 3, 11});
    tv.push_back('{1, 0, 0, 15});
    tv.push_back('{1, 0, 3, 15});
    tv.push_back('{1, 2, 0, 15});
    tv.push_back('{1, 2, 3, 15});
    tv.push_back('{1, 0, 1, 15});
    tv.push_back('{1, 1, 0, 15});
    tv.push_back('{1, 1, 3, 15});
    tv.push_back('{1, 2, 2, 15});
    tv.push_back('{1, 1, 1, 0});
    tv.push_back('{1, 1, 2, 0});
    tv.push_back('{2, 1, 1, 3});
    tv.push_back('{2, 0, 1, 1});
    tv.push_back('{2, 2, 1, 1});
    tv.push_back('{2, 1, 0, 1});
    tv.push_back('{2, 1, 2, 1});
    tv.push_back('{2, 0, 0, 0});
    tv.push_back('{2, 0, 2, 0});
    tv.push_back('{2, 2, 0, 0});
    tv.push_back('{2, 2, 2, 0});
    tv.push_back('{2, 1, 3, 0});
    tv.push_back('{3, 1, 1, 15});
    tv.push_back('{3, 0, 1, 0});
    tv.push_back('{3, 2, 1, 0});
    tv.push_back('{3, 1, 0, 0});
    tv.push_back('{3, 1, 2, 0});
    tv.push_back('{3, 2, 3, 0});
    repeat (2) @(posedge clk);
    #1;
    chk("reset edge_data", int'(edge_data), 0);
    chk("reset out_ready", int'(out_ready), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset frame_done", int'(frame_done), 0);
    @(negedge clk);
    rst = 1;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < N; j++)
        img[j] = (s == 0) ? j : (s == 1) ? 5 : (j == W + 1) ? ((s == 2) ? 15 : 3) : 0;
      run_frame(img, s, 100, 0, 0, g);
      gt[s] = g;
    end
    foreach (tv[i])
      chk($sformatf("table sel%0d (%0d,%0d)", tv[i].sel, tv[i].r, tv[i].c),
          gt[tv[i].sel][tv[i].r*W+tv[i].c], tv[i].exp);
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      in_ready = 1;
      grey_data = P'(j);
    end
    @(negedge clk);
    in_ready = 0;
    rst = 0;
    @(posedge clk);
    #1;
    oq.delete();
    chk("mid-frame reset out_ready", int'(out_ready), 0);
    chk("mid-frame reset busy", int'(busy), 0);
    @(negedge clk);
    rst = 1;
    repeat (10) @(negedge clk);
    chk("no outputs after abort", oq.size(), 0);
    for (int j = 0; j < N; j++) img[j] = j;
    run_frame(img, 0, 100, 0, 0, g);
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < N; j++) img[j] = $urandom_range(0, MAXP);
      m = $urandom_range(0, 3);
      run_frame(img, m, (f < 6) ? 30 : 100, f < 6, f < 6, g);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
